// File: rtl/dp_pkg.sv
// Shared definitions for the signed post-processing datapath.
//   clog2      : constant-safe ceiling log2 for sizing pointers and sums
//   DATAWIDTH_DEF : default signed sample width
//   fsm_t      : window fill state (FILL until the ring first wraps, then RUN)
package dp_pkg;

  localparam int DATAWIDTH_DEF = 8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fsm_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/sring_buf.sv
// DEPTH x DATAWIDTH signed circular store.
//   Clk, Rst, clr : clock, sync reset, sync clear (both zero entries and pointer)
//   wr_en, wr_data: write wr_data at the write pointer and advance it
//   rd_old        : entry at the write pointer, i.e. the sample being evicted
//   wrap          : this write lands in the last slot (pointer DEPTH-1 -> 0)
module sring_buf
  import dp_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int DEPTH     = 4
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        clr,
  input  logic                        wr_en,
  input  logic signed [DATAWIDTH-1:0] wr_data,
  output logic signed [DATAWIDTH-1:0] rd_old,
  output logic                        wrap
);

  localparam int AW = clog2(DEPTH);

  logic [DEPTH-1:0][DATAWIDTH-1:0] ring;
  logic [AW-1:0]                   wptr;

  // read happens before the overwrite at the same edge
  assign rd_old = ring[wptr];
  assign wrap   = wr_en && (wptr == AW'(DEPTH - 1));

  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      ring <= '0;
      wptr <= '0;
    end else if (wr_en) begin
      ring[wptr] <= wr_data;
      wptr       <= wptr + AW'(1);  // DEPTH is a power of 2: natural wrap
    end
  end

endmodule

// File: rtl/smovsum_stage.sv
// Moving-window sum / floor average over the last DEPTH signed samples.
//   Clk, Rst  : clock, synchronous active-high reset
//   clr       : synchronous window clear (datapath effect identical to Rst)
//   in_data/in_valid/in_ready : sample input handshake (no skid buffer)
//   out_sum   : signed window sum, empty slots count as 0
//   out_avg   : out_sum >>> log2(DEPTH), floor toward -inf
//   out_full  : window holds DEPTH real samples
//   out_valid/out_ready : result handshake, result held under backpressure
module smovsum_stage
  import dp_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF,
  parameter int DEPTH     = 4,
  parameter int SUMWIDTH  = DATAWIDTH + clog2(DEPTH)
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        clr,
  input  logic signed [DATAWIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [SUMWIDTH-1:0]  out_sum,
  output logic signed [DATAWIDTH-1:0] out_avg,
  output logic                        out_full,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int LG = clog2(DEPTH);

  logic                        accept;
  logic signed [DATAWIDTH-1:0] rd_old;
  logic                        wrap;
  logic signed [SUMWIDTH-1:0]  sum;
  logic signed [SUMWIDTH-1:0]  ext_in;
  logic signed [SUMWIDTH-1:0]  ext_old;
  logic signed [SUMWIDTH-1:0]  new_sum;
  fsm_t                        state;

  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  sring_buf #(.DATAWIDTH(DATAWIDTH), .DEPTH(DEPTH)) u_ring (
    .Clk    (Clk),
    .Rst    (Rst),
    .clr    (clr),
    .wr_en  (accept),
    .wr_data(in_data),
    .rd_old (rd_old),
    .wrap   (wrap)
  );

  assign ext_in  = {{(SUMWIDTH-DATAWIDTH){in_data[DATAWIDTH-1]}}, in_data};
  assign ext_old = {{(SUMWIDTH-DATAWIDTH){rd_old[DATAWIDTH-1]}}, rd_old};
  // evicted slot is still 0 while filling, so the partial sum stays exact
  assign new_sum = sum + ext_in - ext_old;

  // the sum register is the output; the floor average is its upper bits
  // (arithmetic shift right by LG, which always fits DATAWIDTH)
  assign out_sum = sum;
  assign out_avg = sum[LG +: DATAWIDTH];

  // Fill count is carried by the ring pointer while in FILL; the DEPTH-th
  // accept is exactly the first pointer wrap, after which the count is
  // saturated and the FSM sits in RUN.
  always_ff @(posedge Clk) begin
    if (Rst || clr) begin
      sum       <= '0;
      state     <= FILL;
      out_full  <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      sum       <= new_sum;
      out_full  <= (state == RUN) || wrap;
      out_valid <= 1'b1;
      if (wrap) state <= RUN;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_smovsum_stage.sv
// Directed test of smovsum_stage at DATAWIDTH=8, DEPTH=4 (SUMWIDTH=10).
module tb_smovsum_stage;

  logic              Clk = 1'b0;
  logic              Rst, clr, in_valid, in_ready, out_full, out_valid, out_ready;
  logic signed [7:0] in_data, out_avg;
  logic signed [9:0] out_sum;

  int nerr = 0;
  int nchk = 0;

  always #5 Clk = ~Clk;

  smovsum_stage #(.DATAWIDTH(8), .DEPTH(4)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_sum  (out_sum),
    .out_avg  (out_avg),
    .out_full (out_full),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one rising edge, then settle before sampling
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic outs(input string tag, input int s, input int a,
                      input int f, input int v);
    chk({tag, ".sum"},   int'(out_sum), s);
    chk({tag, ".avg"},   int'(out_avg), a);
    chk({tag, ".full"},  int'(out_full), f);
    chk({tag, ".valid"}, int'(out_valid), v);
  endtask

  task automatic feed(input string tag, input int d, input int s,
                      input int a, input int f);
    in_data  = 8'(d);
    in_valid = 1'b1;
    step();
    outs(tag, s, a, f, 1);
  endtask

  task automatic do_clr();
    in_valid = 1'b0;
    clr      = 1'b1;
    step();
    clr      = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    step(); step();
    Rst = 1'b0;
    outs("reset", 0, 0, 0, 0);
    chk("reset.in_ready", int'(in_ready), 1);

    // ramp, window wraps on the 5th sample
    feed("t1.0", 10,  10,  2, 0);
    feed("t1.1", 20,  30,  7, 0);
    feed("t1.2", 30,  60, 15, 0);
    feed("t1.3", 40, 100, 25, 1);
    feed("t1.4", 50, 140, 35, 1);
    in_valid = 1'b0;
    step();
    chk("t1.drain.valid", int'(out_valid), 0);

    // extreme negatives: -512 is the SUMWIDTH floor
    do_clr();
    feed("t2.0", -128, -128,  -32, 0);
    feed("t2.1", -128, -256,  -64, 0);
    feed("t2.2", -128, -384,  -96, 0);
    feed("t2.3", -128, -512, -128, 1);
    feed("t2.4",  127, -257,  -65, 1);

    // floor average of small negatives
    do_clr();
    feed("t3.0", -1, -1, -1, 0);
    feed("t3.1", -2, -3, -1, 0);
    feed("t3.2",  0, -3, -1, 0);
    feed("t3.3",  0, -3, -1, 1);

    // backpressure holds result and blocks input
    do_clr();
    feed("t4.0", 10, 10, 2, 0);
    out_ready = 1'b0;
    in_data   = 8'sd20;
    #1;
    chk("t4.in_ready_low", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      outs("t4.hold", 10, 2, 0, 1);
      chk("t4.hold.in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4.in_ready_high", int'(in_ready), 1);
    step();
    outs("t4.after", 30, 7, 0, 1);
    in_valid = 1'b0;
    step();
    chk("t4.drain.valid", int'(out_valid), 0);

    // clr with a simultaneous sample: sample must not be consumed
    do_clr();
    feed("t5.0", 10, 10,  2, 0);
    feed("t5.1", 20, 30,  7, 0);
    feed("t5.2", 30, 60, 15, 0);
    in_data = 8'sd99;
    clr     = 1'b1;
    #1;
    chk("t5.clr.in_ready", int'(in_ready), 0);
    step();
    clr = 1'b0;
    outs("t5.cleared", 0, 0, 0, 0);
    feed("t5.after", 5, 5, 1, 0);

    // reset under backpressure discards pending result and window
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    chk("t6.pending.valid", int'(out_valid), 1);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    outs("t6.reset", 0, 0, 0, 0);
    out_ready = 1'b1;
    feed("t6.0", 1, 1, 0, 0);
    feed("t6.1", 1, 2, 0, 0);
    feed("t6.2", 1, 3, 0, 0);
    feed("t6.3", 1, 4, 1, 1);
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/smovsum_stage.md
Name: smovsum_stage

Overview:
Downstream consumer of the registered signed 8-bit datapath result (SADD → SREG output `c`). It accepts a stream of signed samples under a valid/ready handshake and keeps a DEPTH-sample circular window. For each accepted sample it produces the running signed window sum and the floor average. It is the first sequential post-processing stage after the adder/register pair.

Parameters:
DATAWIDTH, 8, signed sample width.
DEPTH, 4, window length in samples; must be a power of 2 and ≥ 2.
SUMWIDTH, DATAWIDTH + log2(DEPTH), signed sum width; sized so overflow is impossible.

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  synchronous, active-high reset
clr  input  1  synchronous window clear; same effect as Rst on the datapath
in_data  input  DATAWIDTH  signed sample (driven from the SREG output `c`)
in_valid  input  1  sample present
in_ready  output  1  stage can accept a sample
out_sum  output  SUMWIDTH  signed window sum
out_avg  output  DATAWIDTH  signed floor average
out_full  output  1  window holds DEPTH real samples
out_valid  output  1  out_* holds an unconsumed result
out_ready  input  1  consumer accepts the result

Behaviour:
- Clock and reset: one clock, `Clk`. Reset is synchronous and active-high on `Rst`.
- Reset values (at a Clk edge with Rst=1):
  - all ring entries = 0; write pointer = 0; fill count = 0; running sum = 0
  - out_sum = 0, out_avg = 0, out_full = 0, out_valid = 0
- Accept condition: accept = in_valid && in_ready.
  - in_ready = !clr && (!out_valid || out_ready). This is combinational; there is no skid buffer.
- On accept at edge k:
  - old = ring[wptr]; ring[wptr] ← in_data
  - sum ← sum + sext(in_data) − sext(old)
  - wptr ← (wptr + 1) mod DEPTH; wraps DEPTH−1 → 0
  - fill count saturates at DEPTH
- Latency: one cycle.
  - After edge k: out_valid = 1, out_sum = the new sum including the sample, out_avg = new_sum >>> log2(DEPTH) (arithmetic shift, floor toward −inf; always fits DATAWIDTH).
  - out_full = 1 iff the fill count after the update equals DEPTH.
- Before the window is full, the empty slots count as 0, so the partial sum is exact.
- State machine (FSM on fill count):
  - FILL (count < DEPTH) → RUN on the DEPTH-th accept.
  - RUN stays in RUN until Rst or clr.
  - In both states, Rst or clr returns the FSM to FILL.
- Output handshake:
  - out_valid clears on out_valid && out_ready && !accept.
  - If a result is consumed and a new sample is accepted in the same cycle, out_valid stays 1 and out_* update.
  - While out_valid=1 and out_ready=0, out_* are held stable and in_ready=0.
- clr (synchronous):
  - clears ring, sum, pointer and count, and sets out_valid=0, out_* = 0.
  - in_ready=0 during clr, so a simultaneous in_valid sample is not consumed; the source must hold it.
- Precedence: Rst > clr > accept.
  - Reset mid-operation discards the pending output and all window state, even under backpressure.
- Width rules: all arithmetic is signed. in_data and ring entries are sign-extended to SUMWIDTH before add/sub.

Decomposition:
- Shared package `dp_pkg`:
  - `clog2` function
  - default DATAWIDTH
  - FSM state encoding: FILL=1'b0, RUN=1'b1
- One natural sub-module, `sring_buf`: DEPTH×DATAWIDTH signed circular store.
  - Inputs: Clk, Rst, clr, wr_en, wr_data.
  - Outputs: rd_old (the entry at wptr, read combinationally before overwrite) and wrap flag.
- The top level holds the sum register, FSM and handshake.

Test Plan:
1. DEPTH=4, out_ready=1, feed 10,20,30,40,50 back-to-back → out_sum 10,30,60,100,140; out_avg 2,7,15,25,35; out_full 0,0,0,1,1; each result one cycle after accept.
2. Feed −128 four times, then 127 → out_sum −128,−256,−384,−512,−257; out_avg at 4th = −128; 5th avg = −65; no overflow at SUMWIDTH=10.
3. Feed −1,−2,0,0 → final out_sum −3, out_avg −1 (floor, not truncation toward 0).
4. Backpressure: out_ready=0 after the first result (sum 10), in_valid=1 with 20 for 3 cycles → in_ready=0, out_sum held at 10, no accept. Raise out_ready → 20 accepted that cycle, next out_sum 30.
5. Pulse clr after 3 samples (sum 60) with in_valid=1 in the same cycle → sample not consumed, out_valid=0, out_full=0. Next accept of 5 → out_sum 5.
6. Assert Rst for one cycle while out_valid=1 and out_ready=0 → next cycle all outputs 0, out_valid=0. Refill 4×1 → out_full rises on the 4th sample, out_sum 4.
